// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle between the debug command path and the
// instruction-memory write port, as seen by the immediate encoder.
interface imm_encoder_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_src;
    logic [WIDTH-1:0] i_base;
    logic [WIDTH-1:0] i_imm;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_instr;
    logic             o_err;
    logic             o_last;

    modport slave (
        input  i_valid, i_src, i_base, i_imm, i_ready,
        output o_ready, o_valid, o_instr, o_err, o_last
    );

    modport master (
        output i_valid, i_src, i_base, i_imm, i_ready,
        input  o_ready, o_valid, o_instr, o_err, o_last
    );
endinterface

// File: rtl/imm_encoder.sv
// Scatters an immediate into an RV32I instruction skeleton with range checks,
// and expands the li pseudo-instruction into one or two machine words.
module imm_encoder #(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    imm_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT,
        S_OUT2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] imm, base;
    logic [31:0]      instr_q, instr_d, buf_q, buf_d;
    logic             err_q, err_d, last_q, last_d;
    logic [31:0]      enc_word, enc_second;
    logic             enc_err, enc_pair;
    logic [4:0]       rd;
    logic [11:0]      lo;
    logic [19:0]      hi;
    logic             ok12, ok13, ok21;
    logic             accept, drain;

    assign imm  = bus.i_imm;
    assign base = bus.i_base;
    assign rd   = base[11:7];
    assign lo   = imm[11:0];
    // ADDI sign-extends lo, so the upper part is rounded up when lo is negative
    assign hi   = imm[31:12] + {19'd0, imm[11]};

    assign ok12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign ok13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign ok21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word   = '0;
        enc_second = '0;
        enc_err    = 1'b0;
        enc_pair   = 1'b0;
        case (bus.i_src)
            3'b000: begin
                enc_word = {imm[11:0], base[19:0]};
                enc_err  = !ok12;
            end
            3'b001: begin
                enc_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                enc_err  = !ok12;
            end
            3'b010: begin
                enc_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                enc_err  = !ok13 || imm[0];
            end
            3'b011: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                enc_err  = !ok21 || imm[0];
            end
            3'b100: begin
                enc_word = {imm[31:12], base[11:0]};
                enc_err  = |imm[11:0];
            end
            3'b101: begin
                if (hi == 20'd0) begin
                    enc_word = {lo, 5'd0, 3'b000, rd, 7'b0010011};
                end else if (lo == 12'd0) begin
                    enc_word = {hi, rd, 7'b0110111};
                end else begin
                    enc_word   = {hi, rd, 7'b0110111};
                    enc_second = {lo, rd, 3'b000, rd, 7'b0010011};
                    enc_pair   = 1'b1;
                end
            end
            default: begin
                enc_word = 32'h0000_0013;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign bus.o_ready = !i_rst && (state == S_IDLE || (state == S_OUT && bus.i_ready));
    assign accept      = bus.i_valid && bus.o_ready;
    assign drain       = (state != S_IDLE) && bus.i_ready;

    // A new request may land in the same cycle the held final word drains
    always_comb begin
        state_next = state;
        instr_d    = instr_q;
        err_d      = err_q;
        last_d     = last_q;
        buf_d      = buf_q;
        if (accept) begin
            state_next = enc_pair ? S_OUT2 : S_OUT;
            instr_d    = enc_word;
            err_d      = enc_err;
            last_d     = !enc_pair;
            buf_d      = enc_second;
        end else if (drain) begin
            case (state)
                S_OUT2: begin
                    state_next = S_OUT;
                    instr_d    = buf_q;
                    err_d      = 1'b0;
                    last_d     = 1'b1;
                end
                S_OUT:   state_next = S_IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state   <= state_next;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.o_valid = (state != S_IDLE);
    assign bus.o_instr = instr_q;
    assign bus.o_err   = err_q;
    assign bus.o_last  = last_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a driver queues expected words as it issues
// requests and a monitor pops and compares every word the DUT hands over.
module tb_imm_encoder;
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    int   assert_count = 0;
    int   fail_count   = 0;
    int   words_seen   = 0;
    int   words_before;
    exp_t exp_q[$];
    exp_t mon_exp;

    imm_encoder_if #(.WIDTH(32)) bus ();

    imm_encoder #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [31:0] instr, input logic err, input logic last);
        exp_t e;
        e.instr = instr;
        e.err   = err;
        e.last  = last;
        exp_q.push_back(e);
    endtask

    // Presents a request and holds it until the DUT takes it at a clock edge.
    task automatic applyStimulus(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm);
        int waited = 0;
        bus.i_valid = 1'b1;
        bus.i_src   = src;
        bus.i_base  = base;
        bus.i_imm   = imm;
        forever begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                bus.i_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_pending", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_word: got 0x%08h, expected none", bus.o_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("word_instr", bus.o_instr, mon_exp.instr);
                checkOutput("word_err", {31'd0, bus.o_err}, {31'd0, mon_exp.err});
                checkOutput("word_last", {31'd0, bus.o_last}, {31'd0, mon_exp.last});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_src   = 3'b000;
        bus.i_base  = 32'h0000_0093;
        bus.i_imm   = 32'hFFFF_FFFF;
        bus.i_ready = 1'b1;

        // Reset with a request pending: nothing may be accepted or emitted
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_o_ready", {31'd0, bus.o_ready}, 32'd0);
            checkOutput("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        checkOutput("rst_no_words", words_seen, 32'd0);

        pushExpect(32'hFFF0_0093, 1'b0, 1'b1);
        applyStimulus(3'b000, 32'h0000_0093, 32'hFFFF_FFFF);
        checkOutput("latency_o_valid", {31'd0, bus.o_valid}, 32'd1);
        waitDrain();

        pushExpect(32'h0000_00E3, 1'b0, 1'b1);
        applyStimulus(3'b010, 32'h0000_0063, 32'h0000_0800);
        pushExpect(32'h8000_0063, 1'b0, 1'b1);
        applyStimulus(3'b010, 32'h0000_0063, 32'hFFFF_F000);
        pushExpect(32'h0000_0163, 1'b1, 1'b1);
        applyStimulus(3'b010, 32'h0000_0063, 32'h0000_0003);
        waitDrain();

        // Four back-to-back single-word requests with the sink always ready
        pushExpect(32'h1200_21A3, 1'b0, 1'b1);
        pushExpect(32'hFFFF_F0EF, 1'b0, 1'b1);
        pushExpect(32'h1234_5537, 1'b0, 1'b1);
        pushExpect(32'h0000_1537, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1'b1;
            case (k)
                0: begin bus.i_src = 3'b001; bus.i_base = 32'h0000_2023; bus.i_imm = 32'h0000_0123; end
                1: begin bus.i_src = 3'b011; bus.i_base = 32'h0000_00EF; bus.i_imm = 32'hFFFF_FFFE; end
                2: begin bus.i_src = 3'b100; bus.i_base = 32'h0000_0537; bus.i_imm = 32'h1234_5000; end
                default: begin bus.i_src = 3'b100; bus.i_base = 32'h0000_0537; bus.i_imm = 32'h0000_1001; end
            endcase
            @(negedge clk);
            checkOutput("stream_o_ready", {31'd0, bus.o_ready}, 32'd1);
            if (k > 0) checkOutput("stream_o_valid", {31'd0, bus.o_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_last_valid", {31'd0, bus.o_valid}, 32'd1);
        waitDrain();

        pushExpect(32'h1234_52B7, 1'b0, 1'b0);
        pushExpect(32'h6782_8293, 1'b0, 1'b1);
        applyStimulus(3'b101, 32'h0000_0280, 32'h1234_5678);
        pushExpect(32'h0000_12B7, 1'b0, 1'b0);
        pushExpect(32'h8002_8293, 1'b0, 1'b1);
        applyStimulus(3'b101, 32'h0000_0280, 32'h0000_0800);
        pushExpect(32'h8000_0293, 1'b0, 1'b1);
        applyStimulus(3'b101, 32'h0000_0280, 32'hFFFF_F800);
        waitDrain();

        // Backpressure on an LI pair with a second request waiting
        bus.i_ready = 1'b0;
        pushExpect(32'h1234_52B7, 1'b0, 1'b0);
        pushExpect(32'h6782_8293, 1'b0, 1'b1);
        pushExpect(32'h0050_0013, 1'b0, 1'b1);
        applyStimulus(3'b101, 32'h0000_0280, 32'h1234_5678);
        bus.i_valid = 1'b1;
        bus.i_src   = 3'b000;
        bus.i_base  = 32'h0000_0013;
        bus.i_imm   = 32'h0000_0005;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_o_valid", {31'd0, bus.o_valid}, 32'd1);
            checkOutput("stall_o_instr", bus.o_instr, 32'h1234_52B7);
            checkOutput("stall_o_ready", {31'd0, bus.o_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        checkOutput("out2_o_ready", {31'd0, bus.o_ready}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 32'h0000_0013, 32'h0000_0005);
        waitDrain();

        // Reset while the LUI is held and the ADDI is buffered
        bus.i_ready = 1'b0;
        applyStimulus(3'b101, 32'h0000_0280, 32'h1234_5678);
        @(negedge clk);
        checkOutput("pair_held_valid", {31'd0, bus.o_valid}, 32'd1);
        checkOutput("pair_held_last", {31'd0, bus.o_last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_comb_o_ready", {31'd0, bus.o_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.i_ready = 1'b1;
        checkOutput("rst_out2_o_valid", {31'd0, bus.o_valid}, 32'd0);
        words_before = words_seen;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_out2_no_words", words_seen, words_before);

        pushExpect(32'h0000_0013, 1'b1, 1'b1);
        applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h0000_0000);
        waitDrain();

        repeat (2) @(posedge clk);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
